// File: rtl/regfile_write_arbiter_if.sv
// Bundle of WB, LU result, issue/hazard and register-file write-port signals
// seen by regfile_write_arbiter.
interface regfile_write_arbiter_if;
    // Writeback stage
    logic        wb_valid;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;

    // Long-latency unit result
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_idx;
    logic [31:0] lu_data;

    // Decode issue and hazard check
    logic        issue_valid;
    logic [4:0]  issue_idx;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        hazard;
    logic [31:0] busy_mask;
    logic        stall_req;

    // Register file write port
    logic        rf_wr_en;
    logic [4:0]  rf_wr_idx;
    logic [31:0] rf_wr_data;
    logic        err;

    // Arbiter view
    modport master (
        input  wb_valid, wb_idx, wb_data,
        input  lu_valid, lu_idx, lu_data,
        input  issue_valid, issue_idx, chk_rs1, chk_rs2, chk_rd,
        output lu_ready, hazard, busy_mask, stall_req,
        output rf_wr_en, rf_wr_idx, rf_wr_data, err
    );

    // Pipeline / register-file view
    modport slave (
        output wb_valid, wb_idx, wb_data,
        output lu_valid, lu_idx, lu_data,
        output issue_valid, issue_idx, chk_rs1, chk_rs2, chk_rd,
        input  lu_ready, hazard, busy_mask, stall_req,
        input  rf_wr_en, rf_wr_idx, rf_wr_data, err
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between WB and a FIFO of long-latency results,
// with a destination scoreboard for decode hazards and a starvation-driven WB stall.
module regfile_write_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                     clk,
    input logic                     reset,
    regfile_write_arbiter_if.master bus
);

    localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    // FIFO storage has no reset; emptiness is tracked by count_q alone.
    logic [4:0]  idx_mem  [FIFO_DEPTH];
    logic [31:0] data_mem [FIFO_DEPTH];

    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic               stall_q, stall_d;
    logic [31:0]        busy_q, busy_d;
    logic               err_q, err_d;

    logic        fifo_empty;
    logic        lu_ready;
    logic        push;
    logic        pop;
    logic        wb_eff;
    logic        wb_take;
    logic [4:0]  head_idx;
    logic [31:0] head_data;

    assign fifo_empty = (count_q == '0);
    assign lu_ready   = (count_q < CntW'(FIFO_DEPTH));
    assign push       = bus.lu_valid & lu_ready;
    assign head_idx   = idx_mem[rd_ptr_q];
    assign head_data  = data_mem[rd_ptr_q];

    assign wb_eff  = bus.wb_valid & (bus.wb_idx != 5'd0);
    assign wb_take = wb_eff & ~stall_q;
    // The FIFO drains whenever WB does not claim the port, including x0 writes.
    assign pop     = ~wb_take & ~fifo_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        stall_d  = stall_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (wb_take && (starve_q != StarveW'(STARVE_LIMIT))) begin
            starve_d = starve_q + StarveW'(1);
        end
        if (pop) begin
            stall_d = 1'b0;
        end else if (starve_d == StarveW'(STARVE_LIMIT)) begin
            stall_d = 1'b1;
        end
    end

    // Clear first so that a same-edge issue to the popped index keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (pop && (head_idx != 5'd0)) begin
            busy_d[head_idx] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_idx != 5'd0)) begin
            busy_d[bus.issue_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        err_d = err_q;
        if (bus.issue_valid && (bus.issue_idx != 5'd0) && busy_q[bus.issue_idx]) begin
            err_d = 1'b1;
        end
        if (wb_eff && stall_q) begin
            err_d = 1'b1;
        end
        if (pop && (head_idx != 5'd0) && !busy_q[head_idx]) begin
            err_d = 1'b1;
        end
        if (bus.lu_valid && !lu_ready && !busy_q[bus.lu_idx]) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            busy_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            idx_mem[wr_ptr_q]  <= bus.lu_idx;
            data_mem[wr_ptr_q] <= bus.lu_data;
        end
    end

    // Write port; held idle during reset even if WB is presenting a write.
    always_comb begin
        bus.rf_wr_en   = 1'b0;
        bus.rf_wr_idx  = 5'd0;
        bus.rf_wr_data = 32'd0;
        if (!reset) begin
            if (wb_take) begin
                bus.rf_wr_en   = 1'b1;
                bus.rf_wr_idx  = bus.wb_idx;
                bus.rf_wr_data = bus.wb_data;
            end else if (pop && (head_idx != 5'd0)) begin
                bus.rf_wr_en   = 1'b1;
                bus.rf_wr_idx  = head_idx;
                bus.rf_wr_data = head_data;
            end
        end
    end

    assign bus.lu_ready  = lu_ready;
    assign bus.busy_mask = busy_q;
    assign bus.stall_req = stall_q;
    assign bus.err       = err_q;
    assign bus.hazard    = busy_q[bus.chk_rs1] | busy_q[bus.chk_rs2] | busy_q[bus.chk_rd];

endmodule
